md_scheduler: RTL

MD_SCHEDULER -- requirements
Module: md_scheduler

---
 rtl/md_scheduler_pkg.sv | 17 +
 rtl/md_scheduler_arith.sv | 28 ++
 rtl/md_scheduler.sv | 76 +++++++
 3 files changed

// File: rtl/md_scheduler_pkg.sv
// md_scheduler_pkg: HI/LO multiply-divide unit operation codes and default latencies.
package md_scheduler_pkg;
   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_e;
   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF = 10;
   // Long ops occupy codes 0..3; bit 1 separates divide from multiply
   function automatic logic is_long(input logic [2:0] op);
      return !op[2];
   endfunction
endpackage

// File: rtl/md_scheduler_arith.sv
// md_arith: combinational MULT/MULTU/DIV/DIVU result generator, {HI,LO} packed into 64 bits.
module md_arith
   import md_scheduler_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] res,
   output logic        div_zero
);
   logic        sgn, neg_a, neg_b;
   logic [31:0] mag_a, mag_b, q, r;
   logic [63:0] prod;
   // Sign-magnitude arithmetic keeps 0x80000000 / -1 well defined (wraps back to 0x80000000)
   always_comb begin
      sgn = (op == MD_MULT) || (op == MD_DIV);
      neg_a = sgn & a[31];
      neg_b = sgn & b[31];
      mag_a = neg_a ? -a : a;
      mag_b = neg_b ? -b : b;
      prod = {32'd0, mag_a} * {32'd0, mag_b};
      div_zero = b == 32'd0;
      q = div_zero ? 32'd0 : mag_a / mag_b;
      r = div_zero ? 32'd0 : mag_a % mag_b;
      res = op[1] ? {neg_a ? -r : r, (neg_a ^ neg_b) ? -q : q}
                  : ((neg_a ^ neg_b) ? -prod : prod);
   end
endmodule

// File: rtl/md_scheduler.sv
// md_scheduler: HI/LO multiply-divide unit; holds a long-op result until its latency expires,
// then commits it to HI/LO. Callers stall on busy | op_valid.
module md_scheduler
   import md_scheduler_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic [2:0]  md_op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        rd_sel,
   output logic        busy,
   output logic [31:0] rdata,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAXC + 1);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN = 1'b1;
   logic [0:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   hi_q, hi_d, lo_q, lo_d;
   logic [63:0]   pend_q, pend_d, res;
   logic          wr_q, wr_d, div_zero, start;
   md_arith u_arith (.op(md_op), .a(src_a), .b(src_b), .res(res), .div_zero(div_zero));
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      hi_d = hi_q;
      lo_d = lo_q;
      pend_d = pend_q;
      wr_d = wr_q;
      start = op_valid && state_q == IDLE && is_long(md_op);
      if (state_q == RUN) begin
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CW'(1)) begin
            state_d = IDLE;
            if (wr_q) {hi_d, lo_d} = pend_q;
         end
      end else if (start) begin
         state_d = RUN;
         cnt_d = md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
         pend_d = res;
         wr_d = !(md_op[1] && div_zero);
      end else if (op_valid) begin
         hi_d = (md_op == MD_MTHI) ? src_a : hi_q;
         lo_d = (md_op == MD_MTLO) ? src_a : lo_q;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q <= '0;
         hi_q <= '0;
         lo_q <= '0;
         pend_q <= '0;
         wr_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         hi_q <= hi_d;
         lo_q <= lo_d;
         pend_q <= pend_d;
         wr_q <= wr_d;
      end
   end
   assign busy = state_q == RUN;
   assign rdata = rd_sel ? hi_q : lo_q;
   assign hi = hi_q;
   assign lo = lo_q;
endmodule
